count_monitor: RTL and testbench

- Downstream checker for the 4-bit free-running up-counter. Samples the counter output `q` every clock.
- Locks onto the +1 sequence and reports wrap-around events as a pulse plus a saturating wrap count.
- Raises sticky errors for skipped values and for stalls that run too long.
- Sits beside the counter in the test project: on the bench and as an on-chip health monitor.

---
 rtl/count_monitor.sv | 90 +++++++++
 tb/tb_count_monitor.sv | 127 ++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// count_monitor: tracks counter q_in (clk, clr, en, err_clr) and reports locked, wrap_pulse, wrap_cnt, skip_err, stall_err
module count_monitor #(
    parameter int WIDTH       = 4,
    parameter int STALL_LIMIT = 8,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [WIDTH-1:0]  q_in,
    input  logic              err_clr,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              skip_err,
    output logic              stall_err
);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAULT} state_t;
    state_t            state;
    logic [WIDTH-1:0]  q_prev;
    logic [WIDTH-1:0]  succ;
    logic [SW-1:0]     stall_run;
    logic [SW-1:0]     run_nxt;
    always_comb begin
        succ    = q_prev + 1'b1;
        run_nxt = stall_run + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            q_prev     <= '0;
            stall_run  <= '0;
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            skip_err   <= 1'b0;
            stall_err  <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (err_clr) begin
                state     <= IDLE;
                locked    <= 1'b0;
                stall_run <= '0;
                skip_err  <= 1'b0;
                stall_err <= 1'b0;
            end else if (!en) begin
                state     <= IDLE;
                locked    <= 1'b0;
                stall_run <= '0;
            end else begin
                q_prev <= q_in;
                case (state)
                    IDLE: begin
                        locked <= 1'b0;
                        state  <= SYNC;
                    end
                    SYNC: begin
                        if (q_in == succ) begin
                            state  <= TRACK;
                            locked <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (q_in == succ) begin
                            stall_run <= '0;
                            if (&q_prev) begin
                                wrap_pulse <= 1'b1;
                                wrap_cnt   <= &wrap_cnt ? wrap_cnt : wrap_cnt + 1'b1;
                            end
                        end else if (q_in == q_prev) begin
                            stall_run <= run_nxt;
                            if (run_nxt == SW'(STALL_LIMIT)) begin
                                stall_err <= 1'b1;
                                locked    <= 1'b0;
                                state     <= FAULT;
                            end
                        end else begin
                            skip_err <= 1'b1;
                            locked   <= 1'b0;
                            state    <= FAULT;
                        end
                    end
                    FAULT: locked <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: scoreboard bench for count_monitor at WRAP_W=8 and WRAP_W=2
module tb_count_monitor;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       locked, wrap_pulse, skip_err, stall_err;
    logic [7:0] wrap_cnt;
    logic       b_locked, b_pulse, b_skip, b_stall;
    logic [1:0] b_cnt;
    typedef struct {
        int    l;
        int    p;
        int    w;
        int    w2;
        int    sk;
        int    st;
        string t;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int ew = 0;
    count_monitor #(.WIDTH(4), .STALL_LIMIT(8), .WRAP_W(8)) dut (
        .clk(clk), .clr(clr), .en(en), .q_in(q_in), .err_clr(err_clr),
        .locked(locked), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt),
        .skip_err(skip_err), .stall_err(stall_err)
    );
    count_monitor #(.WIDTH(4), .STALL_LIMIT(8), .WRAP_W(2)) dut2 (
        .clk(clk), .clr(clr), .en(en), .q_in(q_in), .err_clr(err_clr),
        .locked(b_locked), .wrap_pulse(b_pulse), .wrap_cnt(b_cnt),
        .skip_err(b_skip), .stall_err(b_stall)
    );
    always #5 clk = ~clk;
    task automatic chk(input string t, input string f, input int a, input int e);
        if (e >= 0) begin
            checks++;
            if (a != e) begin
                failures++;
                $display("FAIL %s.%s got=%0d exp=%0d", t, f, a, e);
            end
        end
    endtask
    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk(x.t, "locked", int'(locked), x.l);
            chk(x.t, "wrap_pulse", int'(wrap_pulse), x.p);
            chk(x.t, "wrap_cnt", int'(wrap_cnt), x.w);
            chk(x.t, "skip_err", int'(skip_err), x.sk);
            chk(x.t, "stall_err", int'(stall_err), x.st);
            chk(x.t, "sat_pulse", int'(b_pulse), x.p);
            chk(x.t, "sat_cnt", int'(b_cnt), x.w2);
        end
    end
    task automatic cyc(input logic c, input logic e, input logic ec, input int qv,
                       input int l, input int p, input int w, input int w2,
                       input int sk, input int st, input string t);
        exp_t x;
        @(negedge clk);
        clr = c;
        en = e;
        err_clr = ec;
        q_in = qv[3:0];
        x.l = l; x.p = p; x.w = w; x.w2 = w2; x.sk = sk; x.st = st; x.t = t;
        sb.push_back(x);
    endtask
    task automatic run(input int from, input int n);
        for (int i = 0; i < n; i++) begin
            int v;
            v = (from + i) % 16;
            if (v == 0) ew++;
            cyc(0, 1, 0, v, 1, int'(v == 0), ew, ew > 3 ? 3 : ew, 0, 0, "run");
        end
    endtask
    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset2");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "idle2sync");
        cyc(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, "lock");
        run(2, 79);
        run(1, 5);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 5, 1, 0, ew, 3, 0, 0, "hold7");
        run(6, 2);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 7, 1, 0, ew, 3, 0, 0, "hold");
        cyc(0, 1, 0, 7, 0, 0, ew, 3, 0, 1, "stall8");
        cyc(0, 1, 0, 8, 0, 0, ew, 3, 0, 1, "fault_hold");
        cyc(0, 1, 1, 9, 0, 0, ew, 3, 0, 0, "err_clr");
        cyc(0, 1, 0, 10, 0, 0, ew, 3, 0, 0, "resync");
        cyc(0, 1, 0, 11, 1, 0, ew, 3, 0, 0, "relock");
        run(12, 10);
        cyc(0, 1, 0, 7, 0, 0, ew, 3, 1, 0, "skip");
        cyc(0, 1, 1, 8, 0, 0, ew, 3, 0, 0, "clr_skip");
        cyc(0, 1, 0, 9, 0, 0, ew, 3, 0, 0, "sync2");
        cyc(0, 1, 0, 10, 1, 0, ew, 3, 0, 0, "relock2");
        run(11, 11);
        cyc(0, 1, 1, 9, 0, 0, ew, 3, 0, 0, "simul");
        cyc(0, 1, 0, 10, 0, 0, ew, 3, 0, 0, "simul_idle");
        cyc(0, 1, 0, 11, 1, 0, ew, 3, 0, 0, "simul_relock");
        run(12, 4);
        cyc(0, 1, 0, 3, 0, 0, ew, 3, 1, 0, "skip_wrap");
        cyc(0, 0, 0, 4, 0, 0, ew, 3, 1, 0, "en0_keep");
        cyc(0, 1, 1, 4, 0, 0, ew, 3, 0, 0, "clr2");
        cyc(0, 1, 0, 4, 0, 0, ew, 3, 0, 0, "sync3");
        cyc(0, 1, 0, 5, 1, 0, ew, 3, 0, 0, "lock3");
        cyc(0, 0, 0, 6, 0, 0, ew, 3, 0, 0, "en0");
        cyc(0, 1, 0, 7, 0, 0, ew, 3, 0, 0, "sync4");
        cyc(0, 1, 0, 8, 1, 0, ew, 3, 0, 0, "lock4");
        cyc(1, 1, 0, 9, 0, 0, 0, 0, 0, 0, "clr_mid");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "clr_hold");
        @(posedge clk);
        #2;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
